giraffe_adc_emu: RTL and testbench



---
 rtl/giraffe_adc_pkg.sv | 14 +
 rtl/giraffe_adc_emu_lfsr.sv | 26 ++
 rtl/giraffe_adc_emu.sv | 137 +++++++++++++
 tb/tb_giraffe_adc_emu.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/giraffe_adc_pkg.sv
// Shared definitions for the Giraffe ADC die emulator: FSM state encoding and
// the noise LFSR seed/tap constants.
package giraffe_adc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } adc_state_e;

    // Fibonacci x^16+x^14+x^13+x^11+1, taps expressed as state bit positions 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/giraffe_adc_emu_lfsr.sv
// 16-bit Fibonacci LFSR supplying the per-sub-word noise bit of the ADC emulator.
module giraffe_adc_emu_lfsr
    import giraffe_adc_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic step,
    output logic bit_out
);

    logic [15:0] state_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= LFSR_SEED;
        end else if (clr) begin
            state_q <= LFSR_SEED;
        end else if (step) begin
            state_q <= {state_q[14:0], ^(state_q & LFSR_TAPS)};
        end
    end

    assign bit_out = state_q[0];

endmodule

// File: rtl/giraffe_adc_emu.sv
// Behavioural responder for the Giraffe ADC chip interface: pipelined sub-ADC words,
// calibration pattern mode, optional LSB noise under GIRAFFE_ADC_EMU_NOISE_EN.
module giraffe_adc_emu
    import giraffe_adc_pkg::*;
#(
    parameter int unsigned NUM_bit     = 6,
    parameter int unsigned NUM_STAGE   = 3,
    parameter int unsigned CONV_CYCLES = 16
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               adc_rstn,
    input  logic               adc_ena,
    input  logic               adc_calib_ena,
    input  logic [8:0]         adc_NOWA,
    output logic               adc_ack,
    output logic               adc_ack_sub,
    output logic [NUM_bit-1:0] adc_dout
);

    localparam int unsigned W  = NUM_STAGE * NUM_bit;
    localparam int unsigned PW = $clog2(CONV_CYCLES);

    generate
        if (W < 9 || CONV_CYCLES < NUM_STAGE + 2) begin : g_bad_cfg
            $error("giraffe_adc_emu: need NUM_STAGE*NUM_bit >= 9 and CONV_CYCLES >= NUM_STAGE+2");
        end
    endgenerate

    adc_state_e         state_q, state_n;
    logic [PW-1:0]      p_q, p_n;
    logic [W-1:0]       acc_q, acc_n, sample_q, sample_n;
    logic [NUM_bit-1:0] cal_q, cal_n, cal_s_q, cal_s_n;
    logic               mode_q, mode_n;
    logic               ack_n, sub_n;
    logic [NUM_bit-1:0] dout_n;
    logic [W-1:0]       shifted;
    int unsigned        k_idx;

`ifdef GIRAFFE_ADC_EMU_NOISE_EN
    logic noise_bit;

    giraffe_adc_emu_lfsr u_lfsr (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (!adc_rstn),
        .step    (sub_n),
        .bit_out (noise_bit)
    );
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            acc_q       <= '0;
            sample_q    <= '0;
            cal_q       <= '0;
            cal_s_q     <= '0;
            mode_q      <= 1'b0;
            adc_ack     <= 1'b0;
            adc_ack_sub <= 1'b0;
            adc_dout    <= '0;
        end else begin
            state_q     <= state_n;
            p_q         <= p_n;
            acc_q       <= acc_n;
            sample_q    <= sample_n;
            cal_q       <= cal_n;
            cal_s_q     <= cal_s_n;
            mode_q      <= mode_n;
            adc_ack     <= ack_n;
            adc_ack_sub <= sub_n;
            adc_dout    <= dout_n;
        end
    end

    // Outputs are registered from the current period cycle, so cycle p=1 appears one clock later
    always_comb begin
        state_n  = state_q;
        p_n      = p_q;
        acc_n    = acc_q;
        sample_n = sample_q;
        cal_n    = cal_q;
        cal_s_n  = cal_s_q;
        mode_n   = mode_q;
        ack_n    = 1'b0;
        sub_n    = 1'b0;
        dout_n   = '0;
        k_idx    = (p_q == '0) ? 0 : 32'(p_q) - 1;
        shifted  = sample_q << (NUM_bit * k_idx);

        if (!adc_rstn) begin
            state_n  = IDLE;
            p_n      = '0;
            acc_n    = '0;
            sample_n = '0;
            cal_n    = '0;
            cal_s_n  = '0;
            mode_n   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (adc_ena) begin
                        state_n = CONV;
                        p_n     = '0;
                    end
                end
                CONV: begin
                    if (p_q == '0) begin
                        mode_n   = adc_calib_ena;
                        sample_n = acc_q;
                        acc_n    = acc_q + W'(adc_NOWA);
                        cal_n    = cal_q + NUM_bit'(1);
                        cal_s_n  = cal_q;
                    end
                    if (p_q != '0 && k_idx < NUM_STAGE) begin
                        sub_n  = 1'b1;
                        dout_n = mode_q ? cal_s_q + NUM_bit'(k_idx) : shifted[W-1 -: NUM_bit];
`ifdef GIRAFFE_ADC_EMU_NOISE_EN
                        if (!mode_q) dout_n[0] = dout_n[0] ^ noise_bit;
`endif
                    end
                    if (32'(p_q) == NUM_STAGE + 1) ack_n = 1'b1;
                    if (32'(p_q) == CONV_CYCLES - 1) begin
                        p_n     = '0;
                        state_n = adc_ena ? CONV : IDLE;
                    end else begin
                        p_n = p_q + PW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_giraffe_adc_emu.sv
// Directed self-checking bench for giraffe_adc_emu (default build, noise disabled).
module tb_giraffe_adc_emu;

    logic       clk = 1'b0;
    logic       nrst;
    logic       adc_rstn;
    logic       adc_ena;
    logic       adc_calib_ena;
    logic [8:0] adc_NOWA;
    logic       adc_ack;
    logic       adc_ack_sub;
    logic [5:0] adc_dout;

    int vec = 0;
    int miscomp = 0;
    int cyc = 0;

    giraffe_adc_emu #(.NUM_bit(6), .NUM_STAGE(3), .CONV_CYCLES(16)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .adc_rstn      (adc_rstn),
        .adc_ena       (adc_ena),
        .adc_calib_ena (adc_calib_ena),
        .adc_NOWA      (adc_NOWA),
        .adc_ack       (adc_ack),
        .adc_ack_sub   (adc_ack_sub),
        .adc_dout      (adc_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0; adc_rstn = 1'b0; adc_ena = 1'b0; adc_calib_ena = 1'b0; adc_NOWA = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b1; adc_rstn = 1'b1;
        @(negedge clk);
    endtask

    // Captures one conversion: three strobed words (MSB word first) and the ack cycle
    task automatic wait_conv(output logic [17:0] got, output int t_sub, output int t_ack, output bit ok);
        bit found;
        found = 1'b0; got = '0; t_sub = 0; t_ack = 0; ok = 1'b1;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (adc_ack_sub === 1'b1) found = 1'b1;
        end
        if (!found) begin
            ok = 1'b0;
            return;
        end
        t_sub = cyc; got[17:12] = adc_dout;
        @(negedge clk); if (adc_ack_sub !== 1'b1) ok = 1'b0; got[11:6] = adc_dout;
        @(negedge clk); if (adc_ack_sub !== 1'b1) ok = 1'b0; got[5:0] = adc_dout;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (adc_ack === 1'b1) begin
                found = 1'b1;
                t_ack = cyc;
            end
        end
        if (!found) ok = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nrst = 1'b0; adc_rstn = 1'b1; adc_ena = 1'b1; adc_calib_ena = 1'b0; adc_NOWA = 9'd5;
        #1;
        vec++; if (adc_ack !== 1'b0) begin miscomp++; $display("FAIL reset_ack got %b exp 0", adc_ack); end
        vec++; if (adc_ack_sub !== 1'b0) begin miscomp++; $display("FAIL reset_sub got %b exp 0", adc_ack_sub); end
        vec++; if (adc_dout !== 6'd0) begin miscomp++; $display("FAIL reset_dout got %0d exp 0", adc_dout); end
        do_reset();
        repeat (4) @(negedge clk);
        vec++;
        if ({adc_ack, adc_ack_sub, adc_dout} !== 8'd0) begin
            miscomp++; $display("FAIL idle_outputs got %b exp 0", {adc_ack, adc_ack_sub, adc_dout});
        end
    endtask

    task automatic test_normal();
        logic [17:0] got;
        int ts1, ta1, ts2, ta2, ts3, ta3, c0;
        bit ok;
        do_reset();
        adc_NOWA = 9'd5; adc_ena = 1'b1; c0 = cyc;
        wait_conv(got, ts1, ta1, ok);
        vec++; if (!ok) begin miscomp++; $display("FAIL norm_c1_handshake got timeout exp strobes+ack"); end
        vec++; if (got !== 18'd0) begin miscomp++; $display("FAIL norm_c1_words got %h exp 0", got); end
        vec++; if (ts1 - c0 != 3) begin miscomp++; $display("FAIL norm_latency got %0d exp 3", ts1 - c0); end
        vec++; if (ta1 - ts1 != 3) begin miscomp++; $display("FAIL norm_ack_delay got %0d exp 3", ta1 - ts1); end
        @(negedge clk);
        vec++;
        if ({adc_ack, adc_ack_sub, adc_dout} !== 8'd0) begin
            miscomp++; $display("FAIL norm_gap_zero got %b exp 0", {adc_ack, adc_ack_sub, adc_dout});
        end
        wait_conv(got, ts2, ta2, ok);
        vec++; if (!ok || got !== {6'd0, 6'd0, 6'd5}) begin miscomp++; $display("FAIL norm_c2_words got %h exp 00005", got); end
        vec++; if (ts2 - ts1 != 16) begin miscomp++; $display("FAIL norm_period got %0d exp 16", ts2 - ts1); end
        wait_conv(got, ts3, ta3, ok);
        vec++; if (!ok || got !== 18'd10) begin miscomp++; $display("FAIL norm_c3_words got %h exp 0000a", got); end
        vec++; if (ta3 - ta2 != 16) begin miscomp++; $display("FAIL norm_ack_period got %0d exp 16", ta3 - ta2); end
    endtask

    task automatic test_calib();
        logic [17:0] got;
        int ts, ta;
        bit ok;
        do_reset();
        adc_NOWA = 9'd5; adc_calib_ena = 1'b1; adc_ena = 1'b1;
        for (int n = 1; n <= 65; n++) begin
            wait_conv(got, ts, ta, ok);
            if (n == 1) begin
                vec++; if (!ok || got !== {6'd0, 6'd1, 6'd2}) begin miscomp++; $display("FAIL cal_c1 got %h exp %h", got, {6'd0, 6'd1, 6'd2}); end
            end else if (n == 2) begin
                vec++; if (!ok || got !== {6'd1, 6'd2, 6'd3}) begin miscomp++; $display("FAIL cal_c2 got %h exp %h", got, {6'd1, 6'd2, 6'd3}); end
            end else if (n == 64) begin
                vec++; if (!ok || got !== {6'd63, 6'd0, 6'd1}) begin miscomp++; $display("FAIL cal_c64 got %h exp %h", got, {6'd63, 6'd0, 6'd1}); end
            end else if (n == 65) begin
                vec++; if (!ok || got !== {6'd0, 6'd1, 6'd2}) begin miscomp++; $display("FAIL cal_wrap got %h exp %h", got, {6'd0, 6'd1, 6'd2}); end
            end
        end
        adc_calib_ena = 1'b0;
    endtask

    task automatic test_acc_wrap();
        logic [17:0] got, exp_s;
        int ts, ta;
        bit ok;
        do_reset();
        adc_NOWA = 9'h1FF; adc_ena = 1'b1;
        exp_s = '0;
        for (int n = 1; n <= 600; n++) begin
            wait_conv(got, ts, ta, ok);
            vec++;
            if (!ok || got !== exp_s) begin
                miscomp++; $display("FAIL wrap_conv%0d got %h exp %h", n, got, exp_s);
            end
            exp_s = exp_s + 18'd511;
        end
        adc_ena = 1'b0;
    endtask

    task automatic test_drop_ena();
        logic [17:0] got;
        int ts, ta, junk;
        bit ok, found;
        do_reset();
        adc_NOWA = 9'd5; adc_ena = 1'b1;
        wait_conv(got, ts, ta, ok);
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            @(negedge clk);
            if (adc_ack_sub === 1'b1) found = 1'b1;
        end
        got[17:12] = adc_dout;
        @(negedge clk); got[11:6] = adc_dout; adc_ena = 1'b0;
        @(negedge clk); got[5:0] = adc_dout;
        vec++; if (!found || adc_ack_sub !== 1'b1 || got !== 18'd5) begin miscomp++; $display("FAIL drop_words got %h exp 00005", got); end
        @(negedge clk);
        vec++; if (adc_ack !== 1'b1) begin miscomp++; $display("FAIL drop_ack got %b exp 1", adc_ack); end
        junk = 0;
        repeat (40) begin
            @(negedge clk);
            if (adc_ack !== 1'b0 || adc_ack_sub !== 1'b0 || adc_dout !== 6'd0) junk++;
        end
        vec++; if (junk != 0) begin miscomp++; $display("FAIL drop_idle got %0d active cycles exp 0", junk); end
    endtask

    task automatic test_rstn_mid();
        logic [17:0] got;
        int ts, ta, junk;
        bit ok, found;
        do_reset();
        adc_NOWA = 9'd5; adc_ena = 1'b1;
        wait_conv(got, ts, ta, ok);
        found = 1'b0;
        for (int i = 0; i < 32 && !found; i++) begin
            @(negedge clk);
            if (adc_ack_sub === 1'b1) found = 1'b1;
        end
        @(negedge clk); adc_rstn = 1'b0;
        junk = 0;
        repeat (20) begin
            @(negedge clk);
            if (adc_ack !== 1'b0 || adc_ack_sub !== 1'b0 || adc_dout !== 6'd0) junk++;
        end
        vec++; if (!found || junk != 0) begin miscomp++; $display("FAIL rstn_drop got %0d active cycles exp 0", junk); end
        adc_rstn = 1'b1;
        wait_conv(got, ts, ta, ok);
        vec++; if (!ok || got !== 18'd0) begin miscomp++; $display("FAIL rstn_next_sample got %h exp 0", got); end
        wait_conv(got, ts, ta, ok);
        vec++; if (!ok || got !== 18'd5) begin miscomp++; $display("FAIL rstn_acc_cleared got %h exp 00005", got); end
        adc_ena = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; adc_rstn = 1'b0; adc_ena = 1'b0; adc_calib_ena = 1'b0; adc_NOWA = '0;
        test_reset();
        test_normal();
        test_calib();
        test_acc_wrap();
        test_drop_ena();
        test_rstn_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
        $finish;
    end

endmodule
